// File: rtl/calc_alu_pkg.sv
// Shared op codes and FSM state encoding for the sequential calculator ALU.
// Pure type/constant definitions, no logic.
// Imported by seq_alu_core and its testbench.
package calc_alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   // 2'b11 is unused and steers back to S_IDLE.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_ITER = 2'b10
   } state_t;

endpackage

// File: rtl/seq_muldiv_iter.sv
// Shared WIDTH-step datapath: shift-add multiply or restoring divide.
// One step per cycle while step=1; last flags the final step.
// No handshake: the owning FSM decides when to init and step.
module seq_muldiv_iter #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,      // 0 = multiply, 1 = divide
   input  logic               init,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               last
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   // acc upper half: running partial product / remainder.
   // acc lower half: multiplier being shifted out / quotient being shifted in.
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   divisor;
   logic [CNT_W-1:0]   cnt;
   logic               mode_q;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;

   // One iteration of either algorithm, selected by the latched mode.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, divisor});
      // When div_ge holds the true difference is below divisor, so WIDTH bits suffice.
      div_diff  = div_shift[WIDTH-1:0] - divisor;
      if (mode_q) begin
         if (div_ge)
            acc_nxt = {div_diff, acc[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   // Working registers and step counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         divisor <= '0;
         mode_q  <= 1'b0;
         cnt     <= '0;
      end else if (init) begin
         acc     <= {{WIDTH{1'b0}}, a};
         divisor <= b;
         mode_q  <= mode;
         cnt     <= '0;
      end else if (step) begin
         acc     <= acc_nxt;
         cnt     <= cnt + CNT_W'(1);
      end
   end

   assign product   = acc;
   assign quotient  = acc[WIDTH-1:0];
   assign remainder = acc[2*WIDTH-1:WIDTH];
   assign last      = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_alu_core.sv
// Operand-register ALU: ADD/SUB in one cycle, MUL/DIV via WIDTH-step iteration.
// done at edge k+1 (ADD/SUB/DIV-by-0) or k+WIDTH+1 (MUL/DIV) after start edge k.
// start and loads are dropped while busy; no queuing.
module seq_alu_core
   import calc_alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               load_a,
   input  logic               load_b,
   input  logic [1:0]         op,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               flag
);

   state_t             state, state_nxt;
   op_t                op_in, op_q;
   logic [WIDTH-1:0]   reg_a, reg_b, work_a, work_b;
   logic               iter_init, iter_step, iter_last, finish;
   logic [2*WIDTH-1:0] iter_product;
   logic [WIDTH-1:0]   iter_quo, iter_rem;
   logic [WIDTH:0]     add_sum, sub_diff;
   logic [2*WIDTH-1:0] res_nxt;
   logic               flag_nxt;

   assign op_in = op_t'(op);
   assign busy  = (state != S_IDLE);

   seq_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk       (clk),
      .rst       (rst),
      .mode      (op_in == OP_DIV),
      .init      (iter_init),
      .step      (iter_step),
      .a         (reg_a),
      .b         (reg_b),
      .product   (iter_product),
      .quotient  (iter_quo),
      .remainder (iter_rem),
      .last      (iter_last)
   );

   // Next-state and control strobes; DIV by zero skips the iteration entirely.
   always_comb begin
      state_nxt = state;
      iter_init = 1'b0;
      iter_step = 1'b0;
      finish    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               iter_init = 1'b1;
               if (op_in == OP_MUL || (op_in == OP_DIV && reg_b != '0))
                  state_nxt = S_ITER;
               else
                  state_nxt = S_EXEC;
            end
         end
         S_ITER: begin
            iter_step = 1'b1;
            if (iter_last)
               state_nxt = S_EXEC;
         end
         S_EXEC: begin
            finish    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Result and flag for the in-flight op, consumed only on the finishing edge.
   always_comb begin
      add_sum  = {1'b0, work_a} + {1'b0, work_b};
      sub_diff = {1'b0, work_a} - {1'b0, work_b};
      res_nxt  = '0;
      flag_nxt = 1'b0;
      case (op_q)
         OP_ADD: begin
            res_nxt  = {{(WIDTH-1){1'b0}}, add_sum};
            flag_nxt = add_sum[WIDTH];
         end
         OP_SUB: begin
            // Borrow bit doubles as the sign of A-B.
            res_nxt  = {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
            flag_nxt = sub_diff[WIDTH];
         end
         OP_MUL: begin
            res_nxt  = iter_product;
            flag_nxt = |iter_product[2*WIDTH-1:WIDTH];
         end
         OP_DIV: begin
            if (work_b == '0) begin
               res_nxt  = {work_a, {WIDTH{1'b1}}};
               flag_nxt = 1'b1;
            end else begin
               res_nxt  = {iter_rem, iter_quo};
               flag_nxt = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Operand registers accept loads only while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_a <= '0;
         reg_b <= '0;
      end else if (state == S_IDLE) begin
         if (load_a) reg_a <= in_a;
         if (load_b) reg_b <= in_b;
      end
   end

   // Snapshot of operands and op at launch, isolating the running op from later loads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work_a <= '0;
         work_b <= '0;
         op_q   <= OP_ADD;
      end else if (iter_init) begin
         work_a <= reg_a;
         work_b <= reg_b;
         op_q   <= op_in;
      end
   end

   // Output registers: result/flag move only on the finishing edge, done pulses once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         flag   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= finish;
         if (finish) begin
            result <= res_nxt;
            flag   <= flag_nxt;
         end
      end
   end

endmodule
